// File: rtl/yuv422_to_gray.sv
// YUV422 -> GRAY stream converter: drops chroma per pixel, registered output with a
// 2-entry skid buffer, frame geometry checks. Optional macro: YUV422_TO_GRAY_SOF_RESYNC_EN.

module yuv422_to_gray_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [2*DATA_WIDTH-1:0] pix,
    output logic [DATA_WIDTH-1:0]   y
);
    logic unused_chroma;

    assign y             = pix[DATA_WIDTH-1:0];
    assign unused_chroma = ^pix[2*DATA_WIDTH-1:DATA_WIDTH];
endmodule

module yuv422_to_gray #(
    parameter int DATA_WIDTH = 8,
    parameter int PPC        = 4,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         s_axis_yuv_tvalid,
    input  logic [2*DATA_WIDTH*PPC-1:0]  s_axis_yuv_tdata,
    input  logic                         s_axis_yuv_tuser,
    input  logic                         s_axis_yuv_tlast,
    output logic                         s_axis_yuv_tready,
    output logic                         m_axis_gray_tvalid,
    output logic [DATA_WIDTH*PPC-1:0]    m_axis_gray_tdata,
    output logic                         m_axis_gray_tuser,
    output logic                         m_axis_gray_tlast,
    input  logic                         m_axis_gray_tready,
    input  logic                         err_clr,
    output logic                         err_sof,
    output logic                         err_eol_early,
    output logic                         err_eol_late
);
    localparam int BEATS = IMG_WIDTH / PPC;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int OW    = DATA_WIDTH * PPC;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(IMG_HEIGHT - 1);

    typedef struct packed {
        logic [OW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    logic [PPC-1:0][DATA_WIDTH-1:0] y_lane;
    beat_t  in_beat, out_q, skid_q;
    logic   out_vld, skid_full;
    logic   accept, pass, out_free;

    for (genvar i = 0; i < PPC; i++) begin : g_lane
        yuv422_to_gray_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .pix (s_axis_yuv_tdata[2*i*DATA_WIDTH +: 2*DATA_WIDTH]),
            .y   (y_lane[i])
        );
    end

    assign in_beat.data = y_lane;
    assign in_beat.user = s_axis_yuv_tuser;
    assign in_beat.last = s_axis_yuv_tlast;

    // tready is the registered inverse of skid occupancy, so an accept never meets a full skid
    assign s_axis_yuv_tready = ~skid_full;
    assign accept            = s_axis_yuv_tvalid & ~skid_full;
    assign out_free          = ~out_vld | m_axis_gray_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_vld   <= 1'b0;
            out_q     <= '0;
            skid_full <= 1'b0;
            skid_q    <= '0;
        end else if (out_free) begin
            if (skid_full) begin
                out_q     <= skid_q;
                out_vld   <= 1'b1;
                skid_full <= 1'b0;
            end else if (pass) begin
                out_q   <= in_beat;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (pass) begin
            skid_q    <= in_beat;
            skid_full <= 1'b1;
        end
    end

    assign m_axis_gray_tvalid = out_vld;
    assign m_axis_gray_tdata  = out_q.data;
    assign m_axis_gray_tuser  = out_q.user;
    assign m_axis_gray_tlast  = out_q.last;

    logic [BW-1:0] beat_cnt, eff_beat;
    logic [LW-1:0] line_cnt, eff_line;
    logic          frame_done, at_sof, eol, wrap;
    logic          sof_evt, early_evt, late_evt;

    // a tuser beat is treated as beat 0 of line 0 regardless of where the counters were
    assign eff_beat  = s_axis_yuv_tuser ? '0 : beat_cnt;
    assign eff_line  = s_axis_yuv_tuser ? '0 : line_cnt;
    assign at_sof    = (beat_cnt == '0) && (line_cnt == '0);
    assign eol       = s_axis_yuv_tlast || (eff_beat == LAST_BEAT);
    assign wrap      = eol && (eff_line == LAST_LINE);
    assign sof_evt   = accept && (s_axis_yuv_tuser ? !at_sof : (at_sof && frame_done));
    assign early_evt = accept && s_axis_yuv_tlast && (eff_beat != LAST_BEAT);
    assign late_evt  = accept && !s_axis_yuv_tlast && (eff_beat == LAST_BEAT);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt   <= '0;
            line_cnt   <= '0;
            frame_done <= 1'b0;
        end else if (accept) begin
            if (eol) begin
                beat_cnt <= '0;
                line_cnt <= wrap ? '0 : eff_line + LW'(1);
            end else begin
                beat_cnt <= eff_beat + BW'(1);
                line_cnt <= eff_line;
            end
            if (wrap) frame_done <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_sof       <= 1'b0;
            err_eol_early <= 1'b0;
            err_eol_late  <= 1'b0;
        end else begin
            err_sof       <= sof_evt   | (err_sof       & ~err_clr);
            err_eol_early <= early_evt | (err_eol_early & ~err_clr);
            err_eol_late  <= late_evt  | (err_eol_late  & ~err_clr);
        end
    end

`ifdef YUV422_TO_GRAY_SOF_RESYNC_EN
    // beats are swallowed until a tuser; the tuser beat itself resyncs even if it flagged err_sof
    logic synced;

    assign pass = accept & (synced | s_axis_yuv_tuser);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            synced <= 1'b0;
        else if (accept)
            synced <= (synced | s_axis_yuv_tuser) & ~early_evt & ~late_evt
                      & ~(sof_evt & ~s_axis_yuv_tuser);
    end
`else
    assign pass = accept;
`endif

endmodule

// File: tb/tb_yuv422_to_gray.sv
// Self-checking bench for yuv422_to_gray: directed sequences, error-flag vector table,
// randomized frames checked against a queue-based reference of the luma stream.

module tb_yuv422_to_gray;
    localparam int DW    = 8;
    localparam int PPC   = 4;
    localparam int W     = 8;
    localparam int H     = 2;
    localparam int BEATS = W / PPC;
`ifdef YUV422_TO_GRAY_SOF_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic                    aclk = 1'b0;
    logic                    aresetn = 1'b0;
    logic                    s_axis_yuv_tvalid = 1'b0;
    logic [2*DW*PPC-1:0]     s_axis_yuv_tdata = '0;
    logic                    s_axis_yuv_tuser = 1'b0;
    logic                    s_axis_yuv_tlast = 1'b0;
    logic                    s_axis_yuv_tready;
    logic                    m_axis_gray_tvalid;
    logic [DW*PPC-1:0]       m_axis_gray_tdata;
    logic                    m_axis_gray_tuser;
    logic                    m_axis_gray_tlast;
    logic                    m_axis_gray_tready = 1'b1;
    logic                    err_clr = 1'b0;
    logic                    err_sof, err_eol_early, err_eol_late;

    yuv422_to_gray #(.DATA_WIDTH(DW), .PPC(PPC), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_axis_yuv_tvalid  (s_axis_yuv_tvalid),
        .s_axis_yuv_tdata   (s_axis_yuv_tdata),
        .s_axis_yuv_tuser   (s_axis_yuv_tuser),
        .s_axis_yuv_tlast   (s_axis_yuv_tlast),
        .s_axis_yuv_tready  (s_axis_yuv_tready),
        .m_axis_gray_tvalid (m_axis_gray_tvalid),
        .m_axis_gray_tdata  (m_axis_gray_tdata),
        .m_axis_gray_tuser  (m_axis_gray_tuser),
        .m_axis_gray_tlast  (m_axis_gray_tlast),
        .m_axis_gray_tready (m_axis_gray_tready),
        .err_clr            (err_clr),
        .err_sof            (err_sof),
        .err_eol_early      (err_eol_early),
        .err_eol_late       (err_eol_late)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // luma of pixel i is the low byte of its 16-bit YUV word
    function automatic logic [31:0] gray_of(input logic [63:0] w);
        logic [31:0] g;
        for (int i = 0; i < PPC; i++) g[i*8 +: 8] = w[i*16 +: 8];
        return g;
    endfunction

    function automatic logic [63:0] mk_word(input int k);
        logic [63:0] w;
        for (int i = 0; i < PPC; i++) w[i*16 +: 16] = {8'h80, 8'(k*PPC + i + 1)};
        return w;
    endfunction

    typedef struct packed {
        logic [31:0] d;
        logic        u;
        logic        l;
    } exp_t;

    exp_t        q[$];
    bit          sb_en = 1'b0;
    bit          synced = 1'b1;
    int          popped = 0;
    bit          prev_hold = 1'b0;
    logic [33:0] prev_out = '0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            q.delete();
            synced = !RESYNC;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                chk("stall_stable", 64'({m_axis_gray_tvalid, m_axis_gray_tdata, m_axis_gray_tuser,
                    m_axis_gray_tlast}), 64'({1'b1, prev_out}));
            if (sb_en && m_axis_gray_tvalid && m_axis_gray_tready) begin
                if (q.size() == 0) begin
                    chk("sb_extra_beat", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_beat", 64'({m_axis_gray_tdata, m_axis_gray_tuser, m_axis_gray_tlast}),
                        64'(e));
                    popped++;
                end
            end
            if (sb_en && s_axis_yuv_tvalid && s_axis_yuv_tready) begin
                if (s_axis_yuv_tuser) synced = 1'b1;
                if (synced)
                    q.push_back('{d: gray_of(s_axis_yuv_tdata), u: s_axis_yuv_tuser,
                                  l: s_axis_yuv_tlast});
            end
            prev_hold = m_axis_gray_tvalid && !m_axis_gray_tready;
            prev_out  = {m_axis_gray_tdata, m_axis_gray_tuser, m_axis_gray_tlast};
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        s_axis_yuv_tvalid = 1'b0;
        s_axis_yuv_tuser  = 1'b0;
        s_axis_yuv_tlast  = 1'b0;
        err_clr           = 1'b0;
    endtask

    task automatic drive(input logic [63:0] w, input bit u, input bit l);
        s_axis_yuv_tvalid = 1'b1;
        s_axis_yuv_tdata  = w;
        s_axis_yuv_tuser  = u;
        s_axis_yuv_tlast  = l;
    endtask

    task automatic do_reset();
        idle();
        aresetn = 1'b0;
        m_axis_gray_tready = 1'b1;
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic chk_errs(input string name, input bit es, input bit ee, input bit el);
        chk(name, 64'({err_sof, err_eol_early, err_eol_late}), 64'({es, ee, el}));
    endtask

    task automatic send_frame(input bit rand_rdy);
        for (int l = 0; l < H; l++) begin
            for (int b = 0; b < BEATS; b++) begin
                bit acc;
                int tries;
                acc = 1'b0;
                tries = 0;
                s_axis_yuv_tdata = {$urandom, $urandom};
                s_axis_yuv_tuser = (l == 0) && (b == 0);
                s_axis_yuv_tlast = (b == BEATS - 1);
                while (!acc && tries < 100) begin
                    s_axis_yuv_tvalid  = ($urandom_range(0, 3) != 0);
                    m_axis_gray_tready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
                    acc = s_axis_yuv_tvalid && s_axis_yuv_tready;
                    tick();
                    tries++;
                end
                if (!acc) chk("frame_accept_timeout", 64'(0), 64'(1));
            end
        end
        idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle();
        m_axis_gray_tready = 1'b1;
        while ((q.size() != 0 || m_axis_gray_tvalid) && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'(0));
    endtask

    typedef struct packed {
        bit v, u, l, clr, es, ee, el;
    } vec_t;

    vec_t tbl[23];

    initial begin
        logic [31:0] saved;
        tbl = '{7'b1100000, 7'b1010000, 7'b1000000, 7'b1010000, 7'b1100000, 7'b1010000,
                7'b1010010, 7'b0001000, 7'b1100000, 7'b1010000, 7'b1000000, 7'b1010000,
                7'b1100000, 7'b1000001, 7'b0001000, 7'b1000000, 7'b1010000, 7'b1100000,
                7'b1100100, 7'b1010100, 7'b1011010, 7'b1000110, 7'b0001000};

        // reset state
        #2;
        chk("rst_tvalid", 64'(m_axis_gray_tvalid), 64'(0));
        chk("rst_tdata",  64'(m_axis_gray_tdata),  64'(0));
        chk("rst_tuser_tlast", 64'({m_axis_gray_tuser, m_axis_gray_tlast}), 64'(0));
        chk("rst_tready", 64'(s_axis_yuv_tready),  64'(1));
        chk_errs("rst_errs", 0, 0, 0);
        do_reset();

        // clean frame, 1-cycle latency
        sb_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(mk_word(k), k == 0, k % 2 == 1);
            tick();
            chk("A_tvalid", 64'(m_axis_gray_tvalid), 64'(1));
            chk("A_tdata", 64'(m_axis_gray_tdata),
                64'({8'(k*4+4), 8'(k*4+3), 8'(k*4+2), 8'(k*4+1)}));
            chk("A_tuser_tlast", 64'({m_axis_gray_tuser, m_axis_gray_tlast}),
                64'({k == 0, k % 2 == 1}));
        end
        idle();
        tick();
        chk("A_idle_tvalid", 64'(m_axis_gray_tvalid), 64'(0));
        chk_errs("A_errs", 0, 0, 0);

        // backpressure 1,0,0,1
        do_reset();
        popped = 0;
        drive(mk_word(0), 1, 0); m_axis_gray_tready = 1'b1; tick();
        drive(mk_word(1), 0, 1); tick();
        drive(mk_word(2), 0, 0); m_axis_gray_tready = 1'b0;
        chk("B_rdy_before_stall", 64'(s_axis_yuv_tready), 64'(1));
        tick();
        chk("B_rdy_drop", 64'(s_axis_yuv_tready), 64'(0));
        chk("B_hold_data", 64'(m_axis_gray_tdata), 64'(gray_of(mk_word(1))));
        saved = m_axis_gray_tdata;
        drive(mk_word(3), 0, 1); tick();
        chk("B_rdy_still_low", 64'(s_axis_yuv_tready), 64'(0));
        chk("B_data_stable", 64'(m_axis_gray_tdata), 64'(saved));
        m_axis_gray_tready = 1'b1; tick();
        chk("B_rdy_back", 64'(s_axis_yuv_tready), 64'(1));
        chk("B_skid_out", 64'(m_axis_gray_tdata), 64'(gray_of(mk_word(2))));
        tick();
        chk("B_last_out", 64'(m_axis_gray_tdata), 64'(gray_of(mk_word(3))));
        idle();
        repeat (2) tick();
        chk("B_popped", 64'(popped), 64'(4));
        chk("B_queue", 64'(q.size()), 64'(0));

        // reset mid-line with skid full
        do_reset();
        m_axis_gray_tready = 1'b0;
        drive(mk_word(0), 1, 0); tick();
        drive(mk_word(1), 0, 1); tick();
        chk("C_skid_full", 64'(s_axis_yuv_tready), 64'(0));
        aresetn = 1'b0;
        #1;
        chk("C_rst_out", 64'({m_axis_gray_tvalid, m_axis_gray_tuser, m_axis_gray_tlast}), 64'(0));
        chk("C_rst_tdata", 64'(m_axis_gray_tdata), 64'(0));
        chk("C_rst_tready", 64'(s_axis_yuv_tready), 64'(1));
        idle();
        repeat (2) tick();
        aresetn = 1'b1;
        m_axis_gray_tready = 1'b1;
        tick();
        chk("C_tready_after", 64'(s_axis_yuv_tready), 64'(1));
        popped = 0;
        send_frame(1'b0);
        drain();
        chk("C_popped", 64'(popped), 64'(H * BEATS));
        chk_errs("C_errs", 0, 0, 0);

        // error flag vector table
        do_reset();
        sb_en = 1'b0;
        m_axis_gray_tready = 1'b1;
        for (int i = 0; i < 23; i++) begin
            s_axis_yuv_tvalid = tbl[i].v;
            s_axis_yuv_tuser  = tbl[i].u;
            s_axis_yuv_tlast  = tbl[i].l;
            err_clr           = tbl[i].clr;
            s_axis_yuv_tdata  = {$urandom, $urandom};
            tick();
            chk_errs($sformatf("tbl_errs[%0d]", i), tbl[i].es, tbl[i].ee, tbl[i].el);
        end
        idle();

        // randomized clean frames with random gaps and backpressure
        do_reset();
        sb_en = 1'b1;
        popped = 0;
        for (int f = 0; f < 6; f++) send_frame(1'b1);
        drain();
        chk("R_popped", 64'(popped), 64'(6 * H * BEATS));
        chk_errs("R_errs", 0, 0, 0);

        // junk beats before the first tuser
        do_reset();
        popped = 0;
        for (int k = 0; k < 3; k++) begin
            drive(mk_word(10 + k), 0, 0);
            chk("D_junk_tready", 64'(s_axis_yuv_tready), 64'(1));
            tick();
            chk("D_junk_tvalid", 64'(m_axis_gray_tvalid), 64'(!RESYNC));
        end
        for (int k = 0; k < 4; k++) begin
            drive(mk_word(20 + k), k == 0, k % 2 == 1);
            tick();
        end
        drain();
        chk("D_popped", 64'(popped), RESYNC ? 64'(4) : 64'(7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/yuv422_to_gray.md
Name: yuv422_to_gray

Overview:
- Inverse of the gray-to-YUV422 packer on the Stereovision display/capture path.
- Takes a YUV422 AXI4-Stream carrying PPC pixels per beat and strips the chroma. Emits the luma bytes as a GRAY stream that feeds the stereo matching core.
- Registered with a 2-entry skid buffer.
- Checks frame geometry and reports sticky protocol errors.

Parameters:
- DATA_WIDTH, 8: bits per component.
- PPC, 4: pixels per beat.
- IMG_WIDTH, 640: pixels per line; must be a multiple of PPC.
- IMG_HEIGHT, 480: lines per frame.

Ports:
- aclk  in  1  single clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_yuv_tvalid  in  1  input beat valid.
- s_axis_yuv_tdata  in  2*DATA_WIDTH*PPC  pixel i is bits [2*i*DATA_WIDTH +: 2*DATA_WIDTH]; Y in the low DATA_WIDTH bits, chroma (U/V) in the high bits.
- s_axis_yuv_tuser  in  1  start of frame; valid only on the first beat.
- s_axis_yuv_tlast  in  1  end of line.
- s_axis_yuv_tready  out  1  input ready.
- m_axis_gray_tvalid  out  1  output beat valid.
- m_axis_gray_tdata  out  DATA_WIDTH*PPC  pixel i is bits [i*DATA_WIDTH +: DATA_WIDTH] = Y of input pixel i.
- m_axis_gray_tuser  out  1  start of frame, forwarded.
- m_axis_gray_tlast  out  1  end of line, forwarded.
- m_axis_gray_tready  in  1  output ready.
- err_clr  in  1  single-cycle pulse; clears the error flags.
- err_sof  out  1  sticky: tuser seen when not at frame start, or frame start seen without tuser.
- err_eol_early  out  1  sticky: tlast before beat IMG_WIDTH/PPC-1.
- err_eol_late  out  1  sticky: beat IMG_WIDTH/PPC-1 arrived without tlast.

Behaviour:
- Reset (aresetn=0, asynchronous):
  - m_axis_gray_tvalid, tuser, tlast = 0; tdata = 0.
  - s_axis_yuv_tready = 1.
  - All err_* = 0; beat_cnt = 0; line_cnt = 0; skid buffer empty.
- Data path:
  - Per pixel, keep the low DATA_WIDTH bits and drop chroma. No arithmetic.
  - tuser and tlast travel with their beat.
- Handshake:
  - Input accepted when s_tvalid && s_tready.
  - s_tready is a register: s_tready = !skid_full.
  - Latency is 1 cycle from acceptance to m_tvalid=1 when the output stage is empty.
  - Sustained throughput is 1 beat/clk while m_tready=1.
- Skid buffer:
  - If the output stage holds a beat that is not taken (m_tvalid && !m_tready) and an input is accepted, the beat goes to the skid register and s_tready drops the next cycle.
  - When the output beat is taken, the skid beat moves to the output and s_tready returns to 1.
  - m_tdata, tuser and tlast stay stable while m_tvalid && !m_tready.
  - No beat is ever dropped or duplicated.
- Geometry counters advance on each accepted input beat:
  - beat_cnt runs 0..IMG_WIDTH/PPC-1; line_cnt runs 0..IMG_HEIGHT-1.
  - On a beat with tlast: beat_cnt=0; line_cnt increments, wrapping to 0 after IMG_HEIGHT-1.
  - On a beat with tuser: the counters are forced so that this beat is beat 0 of line 0 (resync).
- Error detection, evaluated on accepted beats:
  - tuser when (beat_cnt, line_cnt) != (0, 0) → err_sof.
  - (0, 0) without tuser after a completed frame → err_sof.
  - tlast with beat_cnt < last → err_eol_early.
  - beat_cnt == last without tlast → err_eol_late, and beat_cnt wraps to 0 as if tlast had been seen.
- Error flags:
  - Set one cycle after the offending accept and held until err_clr.
  - If err_clr and a new error occur in the same cycle, set wins.
  - Errors never stall or alter the data stream.
- Reset mid-frame drops any buffered beats. The first frame after reset does not flag err_sof when it starts with tuser.

Optional Feature:
- Macro: YUV422_TO_GRAY_SOF_RESYNC_EN.
- Defined:
  - After reset, and after any err_* event, input beats are accepted (s_tready=1) and discarded, with no output, until a beat with tuser=1 arrives.
  - That beat and all following beats pass through normally.
- Undefined: every accepted beat is forwarded unconditionally.

Test Plan:
- Clean frame, IMG_WIDTH=8, IMG_HEIGHT=2, PPC=4, m_tready=1, input pixel words 0x80nn (Y=nn) → output bytes nn in order, latency 1, tuser on beat 0, tlast on beats 1 and 3, all err_*=0.
- Backpressure: m_tready toggling 1,0,0,1 while s_tvalid=1 → s_tready drops exactly one cycle after the first stall, output sequence is complete and in order, tdata stable during the stall.
- Early tlast on beat 0 of a 2-beat line → err_eol_early=1 the next cycle; err_clr pulse → 0; next clean line raises no error.
- Missing tlast on beat 1 → err_eol_late=1 and line_cnt still advances; a tuser in mid-line → err_sof=1.
- Reset asserted mid-line with the skid buffer full → all outputs at reset values immediately; after release, s_tready=1 and a fresh frame passes cleanly.
- With YUV422_TO_GRAY_SOF_RESYNC_EN: 3 junk beats, then a tuser frame → no output until the tuser beat, then the full frame passes. Without the macro, all 3 junk beats appear at the output.
